sram_port_arbiter: RTL and testbench

Arbitrates one single-port on-chip SRAM between the three Winograd engine requesters: input-tile fetch (0), weight fetch (1) and output writeback (2). Bursts are granted round-robin with zero arbitration latency. The owner keeps the grant (burst lock) until its last beat or a MAX_BURST beat cap. Read data returns one cycle after the read beat, tagged with the requester index.

---
 rtl/sram_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one single-port SRAM between three requesters: input-tile fetch (0),
// weight fetch (1) and output writeback (2). Round-robin burst arbitration
// with zero grant latency; the owner keeps the port until its last beat or
// MAX_BURST beats. Read data comes back one cycle later with a one-hot tag.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   req_i/last_i/we_i [2:0]  per-requester beat request, end-of-burst, write
//   addr_i, wdata_i          per-requester address / write data, packed k-major
//   gnt_o [2:0]              one-hot grant; beat k moves when req_i[k]&gnt_o[k]
//   sram_en_o, sram_we_o     SRAM enable / write enable
//   sram_addr_o, sram_wdata_o SRAM address / write data
//   sram_rdata_i             SRAM read data (one cycle after read enable)
//   rvalid_o [2:0], rdata_o  tagged read return
//   busy_o                   burst lock held
//   owner_o                  current or last grantee
//
// Build option: define SRAM_ARB_WB_PRIORITY_EN to let writeback (2) win
// every idle arbitration; requesters 0/1 still rotate between themselves.

module sram_port_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          req_i,
  input  logic [2:0]          last_i,
  input  logic [2:0]          we_i,
  input  logic [3*ADDR_W-1:0] addr_i,
  input  logic [3*DATA_W-1:0] wdata_i,
  output logic [2:0]          gnt_o,
  output logic                sram_en_o,
  output logic                sram_we_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [DATA_W-1:0]   sram_wdata_o,
  input  logic [DATA_W-1:0]   sram_rdata_i,
  output logic [2:0]          rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                busy_o,
  output logic [1:0]          owner_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [1:0]       owner;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic [2:0]       rd_tag;

  logic [1:0]       win;
  logic             win_vld;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // First requester at or after rr_ptr, modulo 3.
  always_comb begin
    logic [2:0] cand;
    logic [1:0] k;
    win     = '0;
    win_vld = 1'b0;
    cand    = req_i;
    k       = rr_ptr;
`ifdef SRAM_ARB_WB_PRIORITY_EN
    cand[2] = 1'b0;
`endif
    for (int unsigned i = 0; i < 3; i++) begin
      if (!win_vld && cand[k]) begin
        win     = k;
        win_vld = 1'b1;
      end
      k = next_idx(k);
    end
`ifdef SRAM_ARB_WB_PRIORITY_EN
    if (req_i[2]) begin
      win     = 2'd2;
      win_vld = 1'b1;
    end
`endif
  end

  always_comb begin
    gnt_o = '0;
    if (state == IDLE) begin
      if (win_vld) gnt_o[win] = 1'b1;
    end else if (req_i[owner]) begin
      gnt_o[owner] = 1'b1;
    end
  end

  // Grant is one-hot and only ever given to a requester, so an AND-OR mux
  // suffices and leaves every SRAM-side output at zero with no grant.
  always_comb begin
    sram_en_o    = |gnt_o;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (gnt_o[k]) begin
        sram_we_o    = we_i[k];
        sram_addr_o  = addr_i[k*ADDR_W +: ADDR_W];
        sram_wdata_o = wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      rd_tag   <= '0;
    end else begin
      rd_tag <= gnt_o & ~we_i;
      case (state)
        IDLE: begin
          if (win_vld) begin
            owner <= win;
            if (last_i[win] || MAX_BURST == 1) begin
              rr_ptr <= next_idx(win);
            end else begin
              state    <= BURST;
              beat_cnt <= CNT_W'(1);
            end
          end
        end
        BURST: begin
          if (req_i[owner]) begin
            if (last_i[owner] || (beat_cnt + CNT_W'(1)) == CAP) begin
              state    <= IDLE;
              beat_cnt <= '0;
              rr_ptr   <= next_idx(owner);
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o   = (state == BURST);
  assign owner_o  = owner;
  assign rvalid_o = rd_tag;
  assign rdata_o  = sram_rdata_i;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: directed scenarios plus randomized
// traffic, all checked against a cycle-level reference model of the
// arbitration rules and a reference copy of the SRAM contents.

module tb_sram_port_arbiter;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 64;
  localparam int MAX_BURST = 16;
  localparam int DEPTH     = 1 << ADDR_W;

  logic                clk = 1'b0;
  logic                reset;
  logic [2:0]          req, last, we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          gnt;
  logic                sram_en, sram_we;
  logic [ADDR_W-1:0]   sram_addr;
  logic [DATA_W-1:0]   sram_wdata;
  logic [DATA_W-1:0]   sram_rdata;
  logic [2:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic                busy;
  logic [1:0]          owner;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
    .last_i      (last),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .sram_en_o   (sram_en),
    .sram_we_o   (sram_we),
    .sram_addr_o (sram_addr),
    .sram_wdata_o(sram_wdata),
    .sram_rdata_i(sram_rdata),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .busy_o      (busy),
    .owner_o     (owner)
  );

  // Environment SRAM driven by the DUT's SRAM port.
  logic [DATA_W-1:0] env_mem [DEPTH];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) env_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= env_mem[sram_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                m_busy;
  int unsigned       m_own, m_ptr, m_cnt;
  logic [2:0]        m_tag;
  logic [DATA_W-1:0] m_rdata;

  function automatic int pick(input logic [2:0] r, input int unsigned p);
`ifdef SRAM_ARB_WB_PRIORITY_EN
    if (r[2]) return 2;
    r[2] = 1'b0;
`endif
    for (int i = 0; i < 3; i++)
      if (r[(p + i) % 3]) return int'((p + i) % 3);
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_ptr = 0; m_cnt = 0; m_tag = '0;
  endtask

  // Called at a negedge with inputs already applied; checks the cycle,
  // advances the model and returns at the following negedge.
  task automatic cycle();
    int w;
    logic [2:0] eg, ntag;
    logic ew;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    #2;
    if (!m_busy) w = pick(req, m_ptr);
    else         w = req[m_own] ? int'(m_own) : -1;
    eg = '0; ew = 1'b0; ea = '0; ed = '0;
    if (w >= 0) begin
      eg = 3'(1 << w);
      ew = we[w];
      ea = addr[w*ADDR_W +: ADDR_W];
      ed = wdata[w*DATA_W +: DATA_W];
    end
    check("gnt", 64'(gnt), 64'(eg));
    check("sram_en", 64'(sram_en), 64'(w >= 0));
    check("sram_we", 64'(sram_we), 64'(ew));
    check("sram_addr", 64'(sram_addr), 64'(ea));
    check("sram_wdata", sram_wdata, ed);
    check("rvalid", 64'(rvalid), 64'(m_tag));
    check("busy", 64'(busy), 64'(m_busy));
    check("owner", 64'(owner), 64'(m_own));
    if (m_tag != 0) check("rdata", rdata, m_rdata);
    ntag = '0;
    if (w >= 0) begin
      if (ew) ref_mem[ea] = ed;
      else begin ntag = eg; m_rdata = ref_mem[ea]; end
      if (!m_busy) begin
        m_own = w;
        if (last[w] || MAX_BURST == 1) m_ptr = (w + 1) % 3;
        else begin m_busy = 1; m_cnt = 1; end
      end else begin
        m_cnt++;
        if (last[w] || m_cnt == MAX_BURST) begin
          m_busy = 0; m_cnt = 0; m_ptr = (w + 1) % 3;
        end
      end
    end
    m_tag = ntag;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_port(input int k, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    we[k] = w;
    addr[k*ADDR_W +: ADDR_W] = a;
    wdata[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; last = '0; we = '0; addr = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_en", 64'(sram_en), 64'd0);
    check("rst_addr", 64'(sram_addr), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [2:0] rot [4];
    logic [DATA_W-1:0] v;
    rot = '{3'b001, 3'b010, 3'b100, 3'b001};
    reset = 1'b1; req = '0; last = '0; we = '0; addr = '0; wdata = '0;
    sram_rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v = {$urandom, $urandom};
      env_mem[i] = v;
      ref_mem[i] = v;
    end

    // Single-beat read, zero-latency grant, tagged return next cycle
    do_reset();
    req = 3'b001; last = 3'b001; set_port(0, 1'b0, 12'h010, '0);
    #1;
    check("d1_gnt", 64'(gnt), 64'b001);
    check("d1_addr", 64'(sram_addr), 64'h010);
    cycle();
    req = '0; last = '0;
    #1;
    check("d1_rvalid", 64'(rvalid), 64'b001);
    check("d1_rdata", rdata, ref_mem[12'h010]);
    cycle();

    // Back-to-back single-beat rotation
    do_reset();
    req = 3'b111; last = 3'b111; we = '0;
    for (int i = 0; i < 4; i++) begin
      #1 check("rot_gnt", 64'(gnt), 64'(rot[i]));
      cycle();
    end

    // Requester 1 four-beat write burst while 0 and 2 request (rr_ptr is 1)
    for (int b = 1; b <= 4; b++) begin
      req = 3'b111; last = (b == 4) ? 3'b010 : 3'b000;
      set_port(1, 1'b1, 12'(12'h100 + b), {$urandom, $urandom});
      #1;
      check("wb_gnt", 64'(gnt), 64'b010);
      check("wb_busy", 64'(busy), 64'(b > 1));
      cycle();
    end
    last = 3'b100;
    #1 check("wb_next", 64'(gnt), 64'b100);
    cycle();

    // Beat cap: requester 0 streams, requester 2 waits
    do_reset();
    req = 3'b101; last = 3'b100; we = '0;
    for (int b = 1; b <= MAX_BURST; b++) begin
      set_port(0, 1'b0, 12'(b), '0);
      #1 check("cap_gnt", 64'(gnt), 64'b001);
      cycle();
    end
    #1 check("cap_release", 64'(gnt), 64'b100);
    cycle();

    // Owner stalls for two cycles mid-burst; beat count must hold
    do_reset();
    req = 3'b001; last = '0; we = '0;
    cycle(); cycle();
    req = 3'b000;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_en", 64'(sram_en), 64'd0);
      check("stall_busy", 64'(busy), 64'd1);
      cycle();
    end
    req = 3'b101; last = 3'b100;
    for (int i = 0; i < MAX_BURST - 2; i++) begin
      #1 check("resume_gnt", 64'(gnt), 64'b001);
      cycle();
    end
    #1 check("resume_release", 64'(gnt), 64'b100);
    cycle();

    // Writeback priority option
    do_reset();
    req = 3'b101; last = 3'b101;
    #1;
`ifdef SRAM_ARB_WB_PRIORITY_EN
    check("prio_gnt", 64'(gnt), 64'b100);
`else
    check("prio_gnt", 64'(gnt), 64'b001);
`endif
    cycle();

    // Reset in the middle of a read burst
    do_reset();
    req = 3'b001; last = '0; we = '0;
    for (int i = 0; i < 4; i++) begin
      set_port(0, 1'b0, 12'($urandom_range(0, 63)), '0);
      cycle();
    end
    reset = 1'b1;
    #1;
    check("mid_rst_rvalid", 64'(rvalid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycle();

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      req  = 3'($urandom_range(0, 7));
      last = '0;
      for (int k = 0; k < 3; k++) begin
        last[k] = ($urandom_range(0, 5) == 0);
        set_port(k, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
                 {$urandom, $urandom});
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
